// File: rtl/cache_controller.sv
// Sequencing FSM between a CPU load/store port, a direct-mapped cache array and main memory.
// Write-through/write-allocate, one access in flight, saturating read hit/miss counters.
module cache_controller #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [DATA_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_busy,
    output logic                  cpu_done,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    input  logic                  cache_hit,
    input  logic [DATA_WIDTH-1:0] cache_rdata,
    output logic [DATA_WIDTH-1:0] cache_addr,
    output logic [DATA_WIDTH-1:0] cache_wdata,
    output logic                  cache_we,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [CNT_WIDTH-1:0]  hit_count,
    output logic [CNT_WIDTH-1:0]  miss_count
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOOKUP = 2'd1,
        S_FILL   = 2'd2,
        S_WMEM   = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [DATA_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_we;
    logic [CNT_WIDTH-1:0]  r_hit_cnt;
    logic [CNT_WIDTH-1:0]  r_miss_cnt;
    logic                  w_hit_inc;
    logic                  w_miss_inc;

    // State, request latch and saturating counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_we       <= 1'b0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && cpu_req) begin
                r_addr  <= cpu_addr;
                r_wdata <= cpu_wdata;
                r_we    <= cpu_we;
            end
            if (w_hit_inc && (r_hit_cnt != '1)) begin
                r_hit_cnt <= r_hit_cnt + CNT_WIDTH'(1);
            end
            if (w_miss_inc && (r_miss_cnt != '1)) begin
                r_miss_cnt <= r_miss_cnt + CNT_WIDTH'(1);
            end
        end
    end

    // Next state and per-state strobes
    always_comb begin
        w_next      = r_state;
        cpu_done    = 1'b0;
        cpu_rdata   = '0;
        cache_wdata = '0;
        cache_we    = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        w_hit_inc   = 1'b0;
        w_miss_inc  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cpu_req) begin
                    w_next = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (r_we) begin
                    // Write-allocate: the line is written whether or not it hit
                    cache_we    = 1'b1;
                    cache_wdata = r_wdata;
                    w_next      = S_WMEM;
                end else if (cache_hit) begin
                    cpu_done  = 1'b1;
                    cpu_rdata = cache_rdata;
                    w_hit_inc = 1'b1;
                    w_next    = S_IDLE;
                end else begin
                    w_miss_inc = 1'b1;
                    w_next     = S_FILL;
                end
            end
            S_FILL: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    cache_we    = 1'b1;
                    cache_wdata = mem_rdata;
                    cpu_rdata   = mem_rdata;
                    cpu_done    = 1'b1;
                    w_next      = S_IDLE;
                end
            end
            S_WMEM: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_ack) begin
                    cpu_done = 1'b1;
                    w_next   = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign cpu_busy   = (r_state != S_IDLE);
    assign cache_addr = r_addr;
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;
    assign hit_count  = r_hit_cnt;
    assign miss_count = r_miss_cnt;

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller: miss/hit, store, zero-latency ack, reset abort,
// request fields changing while busy, and counter saturation on a 2-bit-counter instance.
module tb_cache_controller;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 16;

    logic          clk;
    logic          reset;
    logic          cpu_req;
    logic          cpu_we;
    logic [DW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_busy;
    logic          cpu_done;
    logic [DW-1:0] cpu_rdata;
    logic          cache_hit;
    logic [DW-1:0] cache_rdata;
    logic [DW-1:0] cache_addr;
    logic [DW-1:0] cache_wdata;
    logic          cache_we;
    logic          mem_req;
    logic          mem_we;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic [CW-1:0] hit_count;
    logic [CW-1:0] miss_count;

    // Second instance with 2-bit counters, sharing all inputs
    logic          s_busy, s_done, s_cache_we, s_mem_req, s_mem_we;
    logic [DW-1:0] s_rdata, s_cache_addr, s_cache_wdata, s_mem_addr, s_mem_wdata;
    logic [1:0]    s_hit_count, s_miss_count;

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;
    int n_cwe    = 0;

    cache_controller #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) u_dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_busy(cpu_busy), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
        .cache_hit(cache_hit), .cache_rdata(cache_rdata), .cache_addr(cache_addr),
        .cache_wdata(cache_wdata), .cache_we(cache_we),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    cache_controller #(.DATA_WIDTH(DW), .CNT_WIDTH(2)) u_dut_sat (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_busy(s_busy), .cpu_done(s_done), .cpu_rdata(s_rdata),
        .cache_hit(cache_hit), .cache_rdata(cache_rdata), .cache_addr(s_cache_addr),
        .cache_wdata(s_cache_wdata), .cache_we(s_cache_we),
        .mem_req(s_mem_req), .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .hit_count(s_hit_count), .miss_count(s_miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled on the active edge
    always @(posedge clk) begin
        if (cpu_done) n_done <= n_done + 1;
        if (cache_we) n_cwe  <= n_cwe + 1;
    end

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge; inputs change here, outputs are checked #1 later
    task automatic next_cycle();
        @(negedge clk);
    endtask

    int base_done;
    int base_cwe;

    initial begin
        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        cache_hit = 1'b0; cache_rdata = '0; mem_ack = 1'b0; mem_rdata = '0;
        next_cycle(); next_cycle();
        reset = 1'b0; #1;
        check_eq("rst_busy", 32'(cpu_busy), 32'd0);
        check_eq("rst_done", 32'(cpu_done), 32'd0);
        check_eq("rst_mem_req", 32'(mem_req), 32'd0);
        check_eq("rst_cache_we", 32'(cache_we), 32'd0);
        check_eq("rst_cache_addr", cache_addr, 32'd0);
        check_eq("rst_mem_wdata", mem_wdata, 32'd0);
        check_eq("rst_hits", 32'(hit_count), 32'd0);
        check_eq("rst_misses", 32'(miss_count), 32'd0);

        // 1. Read miss to 0x40, ack 3 cycles after mem_req rises
        base_done = n_done; base_cwe = n_cwe;
        next_cycle(); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40; cache_hit = 1'b0;
        next_cycle(); cpu_req = 1'b0; #1;
        check_eq("t1_lookup_busy", 32'(cpu_busy), 32'd1);
        check_eq("t1_lookup_done", 32'(cpu_done), 32'd0);
        check_eq("t1_lookup_mreq", 32'(mem_req), 32'd0);
        check_eq("t1_cache_addr", cache_addr, 32'h40);
        next_cycle(); #1;
        check_eq("t1_fill_mreq", 32'(mem_req), 32'd1);
        check_eq("t1_fill_mwe", 32'(mem_we), 32'd0);
        check_eq("t1_mem_addr", mem_addr, 32'h40);
        check_eq("t1_miss_cnt", 32'(miss_count), 32'd1);
        for (int i = 0; i < 2; i++) begin
            next_cycle(); #1;
            check_eq("t1_wait_mreq", 32'(mem_req), 32'd1);
            check_eq("t1_wait_done", 32'(cpu_done), 32'd0);
        end
        next_cycle(); mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF; #1;
        check_eq("t1_ack_cwe", 32'(cache_we), 32'd1);
        check_eq("t1_ack_cwdata", cache_wdata, 32'hDEADBEEF);
        check_eq("t1_ack_done", 32'(cpu_done), 32'd1);
        check_eq("t1_ack_rdata", cpu_rdata, 32'hDEADBEEF);
        check_eq("t1_ack_busy", 32'(cpu_busy), 32'd1);
        next_cycle(); mem_ack = 1'b0; mem_rdata = '0; #1;
        check_eq("t1_idle_busy", 32'(cpu_busy), 32'd0);
        check_eq("t1_idle_mreq", 32'(mem_req), 32'd0);
        check_eq("t1_idle_rdata", cpu_rdata, 32'd0);
        check_eq("t1_cwe_pulses", 32'(n_cwe - base_cwe), 32'd1);
        check_eq("t1_done_pulses", 32'(n_done - base_done), 32'd1);
        // Re-read as a hit
        cpu_req = 1'b1; cache_hit = 1'b1; cache_rdata = 32'hDEADBEEF;
        next_cycle(); cpu_req = 1'b0; #1;
        check_eq("t1_hit_done", 32'(cpu_done), 32'd1);
        check_eq("t1_hit_rdata", cpu_rdata, 32'hDEADBEEF);
        check_eq("t1_hit_cwe", 32'(cache_we), 32'd0);
        next_cycle(); cache_hit = 1'b0; cache_rdata = '0; #1;
        check_eq("t1_hit_cnt", 32'(hit_count), 32'd1);
        check_eq("t1_miss_cnt2", 32'(miss_count), 32'd1);
        check_eq("t1_hit_idle", 32'(cpu_busy), 32'd0);

        // 2. Store 0x44 <- 0x12345678, ack on the third WMEM cycle
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h44; cpu_wdata = 32'h12345678;
        next_cycle(); cpu_req = 1'b0; #1;
        check_eq("t2_lookup_cwe", 32'(cache_we), 32'd1);
        check_eq("t2_lookup_cwdata", cache_wdata, 32'h12345678);
        check_eq("t2_lookup_done", 32'(cpu_done), 32'd0);
        for (int i = 0; i < 2; i++) begin
            next_cycle(); #1;
            check_eq("t2_wmem_mreq", 32'(mem_req), 32'd1);
            check_eq("t2_wmem_mwe", 32'(mem_we), 32'd1);
            check_eq("t2_wmem_addr", mem_addr, 32'h44);
            check_eq("t2_wmem_wdata", mem_wdata, 32'h12345678);
            check_eq("t2_wmem_cwe", 32'(cache_we), 32'd0);
            check_eq("t2_wmem_done", 32'(cpu_done), 32'd0);
        end
        next_cycle(); mem_ack = 1'b1; #1;
        check_eq("t2_ack_done", 32'(cpu_done), 32'd1);
        check_eq("t2_ack_cwe", 32'(cache_we), 32'd0);
        next_cycle(); mem_ack = 1'b0; cpu_we = 1'b0; #1;
        check_eq("t2_idle_busy", 32'(cpu_busy), 32'd0);
        check_eq("t2_hit_cnt", 32'(hit_count), 32'd1);
        check_eq("t2_miss_cnt", 32'(miss_count), 32'd1);

        // 3. Read miss with ack in the same cycle mem_req rises, then a stray ack
        cpu_req = 1'b1; cpu_addr = 32'h80;
        next_cycle(); cpu_req = 1'b0; #1;
        check_eq("t3_lookup_done", 32'(cpu_done), 32'd0);
        next_cycle(); mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D; #1;
        check_eq("t3_k0_mreq", 32'(mem_req), 32'd1);
        check_eq("t3_k0_done", 32'(cpu_done), 32'd1);
        check_eq("t3_k0_rdata", cpu_rdata, 32'hCAFEF00D);
        check_eq("t3_k0_miss", 32'(miss_count), 32'd2);
        next_cycle(); #1;
        base_done = n_done; base_cwe = n_cwe;
        check_eq("t3_stray_busy", 32'(cpu_busy), 32'd0);
        check_eq("t3_stray_done", 32'(cpu_done), 32'd0);
        check_eq("t3_stray_cwe", 32'(cache_we), 32'd0);
        next_cycle(); mem_ack = 1'b0; mem_rdata = '0; #1;
        check_eq("t3_after_busy", 32'(cpu_busy), 32'd0);
        check_eq("t3_after_pulses", 32'((n_done - base_done) + (n_cwe - base_cwe)), 32'd0);
        check_eq("t3_after_miss", 32'(miss_count), 32'd2);

        // 4. Reset during FILL, then a late ack
        cpu_req = 1'b1; cpu_addr = 32'hC0;
        next_cycle(); cpu_req = 1'b0;
        next_cycle(); #1;
        check_eq("t4_fill_mreq", 32'(mem_req), 32'd1);
        base_done = n_done; base_cwe = n_cwe;
        reset = 1'b1;
        next_cycle(); reset = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h55; #1;
        check_eq("t4_rst_busy", 32'(cpu_busy), 32'd0);
        check_eq("t4_rst_mreq", 32'(mem_req), 32'd0);
        check_eq("t4_rst_done", 32'(cpu_done), 32'd0);
        check_eq("t4_rst_hits", 32'(hit_count), 32'd0);
        check_eq("t4_rst_misses", 32'(miss_count), 32'd0);
        next_cycle(); mem_ack = 1'b0; mem_rdata = '0; #1;
        check_eq("t4_late_busy", 32'(cpu_busy), 32'd0);
        check_eq("t4_late_pulses", 32'((n_done - base_done) + (n_cwe - base_cwe)), 32'd0);

        // 6. Request fields changed and cpu_req re-pulsed while busy
        base_done = n_done;
        cpu_req = 1'b1; cpu_addr = 32'h100; cpu_wdata = 32'hAAAA;
        next_cycle(); cpu_addr = 32'h200; cpu_wdata = 32'hBBBB; #1;
        check_eq("t6_lookup_addr", cache_addr, 32'h100);
        next_cycle(); cpu_addr = 32'h300; #1;
        check_eq("t6_fill_addr", mem_addr, 32'h100);
        check_eq("t6_fill_wdata", mem_wdata, 32'hAAAA);
        next_cycle(); cpu_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h11; #1;
        check_eq("t6_ack_done", 32'(cpu_done), 32'd1);
        check_eq("t6_ack_addr", mem_addr, 32'h100);
        next_cycle(); mem_ack = 1'b0; mem_rdata = '0; #1;
        check_eq("t6_idle_busy", 32'(cpu_busy), 32'd0);
        next_cycle(); next_cycle(); #1;
        check_eq("t6_single_done", 32'(n_done - base_done), 32'd1);
        check_eq("t6_misses", 32'(miss_count), 32'd1);

        // 5. Five read hits: 2-bit counter pins at 3, 16-bit counter reaches 5
        cache_hit = 1'b1; cache_rdata = 32'h77; cpu_addr = 32'h40;
        for (int i = 1; i <= 5; i++) begin
            cpu_req = 1'b1;
            next_cycle(); cpu_req = 1'b0; #1;
            check_eq("t5_hit_done", 32'(s_done), 32'd1);
            next_cycle(); #1;
            check_eq("t5_sat_hits", 32'(s_hit_count), (i > 3) ? 32'd3 : 32'(i));
        end
        check_eq("t5_wide_hits", 32'(hit_count), 32'd5);
        check_eq("t5_sat_misses", 32'(s_miss_count), 32'd1);
        cache_hit = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
